// File: rtl/unidade_controle_exibicao.sv
// Control unit for the memory game: replays the stored sequence on the LEDs,
// then collects player plays under an inactivity timeout, for a full match.
module unidade_controle_exibicao #(
  parameter int unsigned T_LED     = 1000,
  parameter int unsigned T_APAGA   = 500,
  parameter int unsigned T_INATIVO = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       jogada_igual,
  input  logic       fim_rodada,
  input  logic       fim_jogo,
  output logic       zera_jogada,
  output logic       conta_jogada,
  output logic       zera_rodada,
  output logic       conta_rodada,
  output logic       zeraR,
  output logic       registraR,
  output logic       mostra_leds,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int unsigned T_MAX_LA = (T_LED > T_APAGA) ? T_LED : T_APAGA;
  localparam int unsigned T_MAX    = (T_MAX_LA > T_INATIVO) ? T_MAX_LA : T_INATIVO;
  localparam int unsigned TW       = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    MOSTRA_LED     = 4'h2,
    APAGA_LED      = 4'h3,
    PROXIMO_LED    = 4'h4,
    INICIA_JOGADAS = 4'h5,
    ESPERA_JOGADA  = 4'h6,
    REGISTRA       = 4'h7,
    COMPARA        = 4'h8,
    PROXIMA_JOGADA = 4'h9,
    PROXIMA_RODADA = 4'hA,
    FIM_GANHOU     = 4'hC,
    FIM_TIMEOUT    = 4'hD,
    FIM_PERDEU     = 4'hE
  } estado_t;

  estado_t       estado, estado_prox;
  logic [TW-1:0] timer, timer_prox;

  logic zera_jogada_d, conta_jogada_d, zera_rodada_d, conta_rodada_d;
  logic zeraR_d, registraR_d, mostra_leds_d;
  logic ganhou_d, perdeu_d, timeout_d, pronto_d;

  // Next-state logic
  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL:        if (iniciar) estado_prox = PREPARACAO;
      PREPARACAO:     estado_prox = MOSTRA_LED;
      MOSTRA_LED:     if (timer == TW'(T_LED - 1)) estado_prox = APAGA_LED;
      APAGA_LED:
        if (timer == TW'(T_APAGA - 1))
          estado_prox = fim_rodada ? INICIA_JOGADAS : PROXIMO_LED;
      PROXIMO_LED:    estado_prox = MOSTRA_LED;
      INICIA_JOGADAS: estado_prox = ESPERA_JOGADA;
      ESPERA_JOGADA:
        if (jogada)                            estado_prox = REGISTRA;
        else if (timer == TW'(T_INATIVO - 1))  estado_prox = FIM_TIMEOUT;
      REGISTRA:       estado_prox = COMPARA;
      COMPARA:
        if (!jogada_igual)               estado_prox = FIM_PERDEU;
        else if (fim_rodada && fim_jogo) estado_prox = FIM_GANHOU;
        else if (fim_rodada)             estado_prox = PROXIMA_RODADA;
        else                             estado_prox = PROXIMA_JOGADA;
      PROXIMA_JOGADA: estado_prox = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_prox = MOSTRA_LED;
      FIM_GANHOU, FIM_TIMEOUT, FIM_PERDEU:
        if (iniciar) estado_prox = PREPARACAO;
      default:        estado_prox = INICIAL;
    endcase
  end

  // Timer restarts on every state change and only runs in the timed states
  always_comb begin
    timer_prox = '0;
    if (estado_prox == estado &&
        (estado == MOSTRA_LED || estado == APAGA_LED || estado == ESPERA_JOGADA))
      timer_prox = timer + TW'(1);
  end

  // Moore decode of the upcoming state, so registered outputs track the state register
  always_comb begin
    zera_jogada_d  = 1'b0;
    conta_jogada_d = 1'b0;
    zera_rodada_d  = 1'b0;
    conta_rodada_d = 1'b0;
    zeraR_d        = 1'b0;
    registraR_d    = 1'b0;
    mostra_leds_d  = 1'b0;
    ganhou_d       = 1'b0;
    perdeu_d       = 1'b0;
    timeout_d      = 1'b0;
    pronto_d       = 1'b0;
    case (estado_prox)
      PREPARACAO: begin
        zera_jogada_d = 1'b1;
        zera_rodada_d = 1'b1;
        zeraR_d       = 1'b1;
      end
      MOSTRA_LED:     mostra_leds_d = 1'b1;
      PROXIMO_LED:    conta_jogada_d = 1'b1;
      INICIA_JOGADAS: begin
        zera_jogada_d = 1'b1;
        zeraR_d       = 1'b1;
      end
      REGISTRA:       registraR_d = 1'b1;
      PROXIMA_JOGADA: conta_jogada_d = 1'b1;
      PROXIMA_RODADA: begin
        conta_rodada_d = 1'b1;
        zera_jogada_d  = 1'b1;
      end
      FIM_GANHOU: begin
        ganhou_d = 1'b1;
        pronto_d = 1'b1;
      end
      FIM_PERDEU: begin
        perdeu_d = 1'b1;
        pronto_d = 1'b1;
      end
      FIM_TIMEOUT: begin
        timeout_d = 1'b1;
        perdeu_d  = 1'b1;
        pronto_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= INICIAL;
      timer        <= '0;
      zera_jogada  <= 1'b0;
      conta_jogada <= 1'b0;
      zera_rodada  <= 1'b0;
      conta_rodada <= 1'b0;
      zeraR        <= 1'b0;
      registraR    <= 1'b0;
      mostra_leds  <= 1'b0;
      ganhou       <= 1'b0;
      perdeu       <= 1'b0;
      timeout      <= 1'b0;
      pronto       <= 1'b0;
      db_estado    <= 4'h0;
    end else begin
      estado       <= estado_prox;
      timer        <= timer_prox;
      zera_jogada  <= zera_jogada_d;
      conta_jogada <= conta_jogada_d;
      zera_rodada  <= zera_rodada_d;
      conta_rodada <= conta_rodada_d;
      zeraR        <= zeraR_d;
      registraR    <= registraR_d;
      mostra_leds  <= mostra_leds_d;
      ganhou       <= ganhou_d;
      perdeu       <= perdeu_d;
      timeout      <= timeout_d;
      pronto       <= pronto_d;
      db_estado    <= estado_prox;
    end
  end

endmodule

// File: tb/tb_unidade_controle_exibicao.sv
// Bench for unidade_controle_exibicao: directed scenarios with literal expectations
// plus randomized stimulus checked every cycle against a behavioural model.
module tb_unidade_controle_exibicao;

  localparam int unsigned T_LED     = 4;
  localparam int unsigned T_APAGA   = 2;
  localparam int unsigned T_INATIVO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, jogada = 1'b0, jogada_igual = 1'b0;
  logic       fim_rodada = 1'b0, fim_jogo = 1'b0;
  logic       zera_jogada, conta_jogada, zera_rodada, conta_rodada;
  logic       zeraR, registraR, mostra_leds, ganhou, perdeu, timeout, pronto;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  unidade_controle_exibicao #(
    .T_LED(T_LED), .T_APAGA(T_APAGA), .T_INATIVO(T_INATIVO)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .jogada_igual(jogada_igual), .fim_rodada(fim_rodada), .fim_jogo(fim_jogo),
    .zera_jogada(zera_jogada), .conta_jogada(conta_jogada),
    .zera_rodada(zera_rodada), .conta_rodada(conta_rodada),
    .zeraR(zeraR), .registraR(registraR), .mostra_leds(mostra_leds),
    .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game phase code plus cycles spent in it
  int m_st = 0;
  int m_t  = 0;

  always @(negedge reset) begin
    m_st = 0;
    m_t  = 0;
  end

  always @(posedge clock) begin
    int nx;
    if (!reset) begin
      m_st = 0;
      m_t  = 0;
    end else begin
      nx = m_st;
      case (m_st)
        0:  if (iniciar) nx = 1;
        1:  nx = 2;
        2:  if (m_t == T_LED - 1) nx = 3;
        3:  if (m_t == T_APAGA - 1) nx = fim_rodada ? 5 : 4;
        4:  nx = 2;
        5:  nx = 6;
        6:  if (jogada) nx = 7; else if (m_t == T_INATIVO - 1) nx = 13;
        7:  nx = 8;
        8:  nx = !jogada_igual ? 14 : (fim_rodada && fim_jogo) ? 12 : fim_rodada ? 10 : 9;
        9:  nx = 6;
        10: nx = 2;
        12, 13, 14: if (iniciar) nx = 1;
        default: nx = 0;
      endcase
      m_t  = (nx == m_st) ? m_t + 1 : 0;
      m_st = nx;
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clock) begin
    chk("m_db_estado",    int'(db_estado),    m_st);
    chk("m_zera_jogada",  int'(zera_jogada),  int'(m_st == 1 || m_st == 5 || m_st == 10));
    chk("m_conta_jogada", int'(conta_jogada), int'(m_st == 4 || m_st == 9));
    chk("m_zera_rodada",  int'(zera_rodada),  int'(m_st == 1));
    chk("m_conta_rodada", int'(conta_rodada), int'(m_st == 10));
    chk("m_zeraR",        int'(zeraR),        int'(m_st == 1 || m_st == 5));
    chk("m_registraR",    int'(registraR),    int'(m_st == 7));
    chk("m_mostra_leds",  int'(mostra_leds),  int'(m_st == 2));
    chk("m_ganhou",       int'(ganhou),       int'(m_st == 12));
    chk("m_perdeu",       int'(perdeu),       int'(m_st == 13 || m_st == 14));
    chk("m_timeout",      int'(timeout),      int'(m_st == 13));
    chk("m_pronto",       int'(pronto),       int'(m_st >= 12));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Advance n cycles, pinning the state code and LED output to literal values
  task automatic run(input int st, input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk($sformatf("db_estado_%0h", st), int'(db_estado), st);
      chk($sformatf("mostra_leds_%0h", st), int'(mostra_leds), (st == 2) ? 1 : 0);
    end
  endtask

  initial begin
    repeat (2) cyc();
    reset = 1'b1;
    run(0, 3);

    // Round 0 display, then inactivity timeout
    fim_rodada = 1'b1; fim_jogo = 1'b1; jogada_igual = 1'b1;
    iniciar = 1'b1;
    run(1, 1);
    chk("prep_zera_jogada", int'(zera_jogada), 1);
    chk("prep_zera_rodada", int'(zera_rodada), 1);
    chk("prep_zeraR", int'(zeraR), 1);
    iniciar = 1'b0;
    run(2, T_LED); run(3, T_APAGA); run(5, 1); run(6, T_INATIVO);
    run(13, 1);
    chk("to_timeout", int'(timeout), 1);
    chk("to_perdeu", int'(perdeu), 1);
    run(13, 3);

    // Correct play on the last round wins
    iniciar = 1'b1;
    run(1, 1);
    iniciar = 1'b0;
    run(2, T_LED); run(3, T_APAGA); run(5, 1); run(6, 3);
    jogada = 1'b1;
    run(7, 1);
    jogada = 1'b0;
    chk("reg_registraR", int'(registraR), 1);
    run(8, 1);
    chk("cmp_registraR", int'(registraR), 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("win_db", int'(db_estado), 12);
      chk("win_ganhou", int'(ganhou), 1);
      chk("win_pronto", int'(pronto), 1);
    end

    // Play coinciding with expiry wins, then a wrong play
    iniciar = 1'b1;
    run(1, 1);
    iniciar = 1'b0;
    run(2, T_LED); run(3, T_APAGA); run(5, 1); run(6, T_INATIVO - 1);
    jogada = 1'b1; jogada_igual = 1'b0;
    run(7, 1);
    jogada = 1'b0;
    run(8, 1);
    run(14, 1);
    chk("lose_perdeu", int'(perdeu), 1);
    chk("lose_timeout", int'(timeout), 0);
    jogada_igual = 1'b1;

    // Round 1 replay: two LEDs
    fim_rodada = 1'b0;
    iniciar = 1'b1;
    run(1, 1);
    iniciar = 1'b0;
    run(2, T_LED); run(3, T_APAGA); run(4, 1);
    chk("r1_conta_jogada", int'(conta_jogada), 1);
    fim_rodada = 1'b1;
    run(2, T_LED); run(3, T_APAGA); run(5, 1); run(6, 2);

    // Asynchronous reset in the middle of waiting for a play
    reset = 1'b0;
    #1;
    chk("rst_db", int'(db_estado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_mostra", int'(mostra_leds), 0);
    cyc();
    reset = 1'b1;
    run(0, 3);

    // Randomized play, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      cyc();
      reset        = ($urandom_range(0, 599) != 0);
      iniciar      = ($urandom_range(0, 7) == 0);
      jogada       = ($urandom_range(0, 3) == 0);
      jogada_igual = ($urandom_range(0, 7) != 0);
      fim_rodada   = ($urandom_range(0, 1) == 0);
      fim_jogo     = ($urandom_range(0, 3) == 0);
    end
    cyc();
    reset = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_controle_exibicao.md
Name: unidade_controle_exibicao

Overview:
- Moore FSM that sequences the memory-game datapath (jogada/rodada counters, play register, comparator) for a full match.
- Each round has two phases: replay the stored sequence on the LEDs with timed on/off slots, then collect player plays with an inactivity timeout.
- Replaces the plain game control unit in the game top level. Owns an internal cycle timer, so the datapath needs no display or inactivity counters.

Parameters:
- T_LED, 1000, cycles a sequence LED stays lit (≥1)
- T_APAGA, 500, cycles of blank gap after each LED (≥1)
- T_INATIVO, 5000, cycles allowed between plays before timeout (≥1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start/restart request (level)
- jogada  in  1  one-cycle pulse, a play was detected
- jogada_igual  in  1  registered play equals memory word at current address
- fim_rodada  in  1  jogada address == current rodada
- fim_jogo  in  1  rodada == last round
- zera_jogada  out  1  clear jogada/address counter
- conta_jogada  out  1  increment jogada counter
- zera_rodada  out  1  clear rodada counter
- conta_rodada  out  1  increment rodada counter
- zeraR  out  1  clear play register
- registraR  out  1  load play register
- mostra_leds  out  1  drive memory word onto leds
- ganhou  out  1  match won (held)
- perdeu  out  1  wrong play (held)
- timeout  out  1  inactivity loss (held)
- pronto  out  1  match ended (held)
- db_estado  out  4  current state code

Behaviour:
- reset=0 (any time, mid-match included): async to inicial; timer=0; all outputs 0; db_estado=0.
- All outputs are pure Moore decodes of state. Each control pulse lasts one cycle.
- Timer:
  - Width = clog2(max(T_LED,T_APAGA,T_INATIVO)+1).
  - Cleared on every state change; otherwise increments in mostra_led, apaga_led and espera_jogada; holds at 0 in all other states.
- States (db_estado code) and transitions:
  - 0 inicial: iniciar=1 → 1.
  - 1 preparacao: zera_jogada, zera_rodada, zeraR → 2.
  - 2 mostra_led: mostra_leds=1; when timer==T_LED-1 → 3. LED is lit for exactly T_LED cycles.
  - 3 apaga_led: when timer==T_APAGA-1 → fim_rodada ? 5 : 4.
  - 4 proximo_led: conta_jogada → 2.
  - 5 inicia_jogadas: zera_jogada, zeraR → 6.
  - 6 espera_jogada:
    - jogada=1 → 7.
    - else timer==T_INATIVO-1 → D.
    - jogada and expiry in the same cycle → 7 (play wins).
  - 7 registra: registraR → 8.
  - 8 compara:
    - !jogada_igual → E.
    - else fim_rodada & fim_jogo → C.
    - else fim_rodada → A.
    - else → 9.
  - 9 proxima_jogada: conta_jogada → 6. Timer restarts, giving each play a full T_INATIVO window.
  - A proxima_rodada: conta_rodada, zera_jogada → 2. Replay restarts from address 0.
  - C fim_ganhou: ganhou=1, pronto=1.
  - E fim_perdeu: perdeu=1, pronto=1.
  - D fim_timeout: timeout=1, perdeu=1, pronto=1.
  - C, D, E: hold until iniciar=1 → 1. Flags drop on leaving.
- Unused codes B, F: next state 0.
- iniciar is ignored outside states 0, C, D, E.
- jogada is ignored outside state 6.
- Round 0 replays one LED; round r replays r+1 LEDs.

Test Plan:
- Reset: pulse reset=0 during state 6 → db_estado=0 asynchronously, all outputs 0. With reset=1 and no iniciar → stays 0.
- Display timing (T_LED=4, T_APAGA=2, fim_rodada=1): iniciar → states 1, 2, 3, 5. mostra_leds high exactly 4 cycles, then low 2 cycles. Exactly one zera_jogada/zera_rodada/zeraR pulse in state 1.
- Round 1 replay: fim_rodada low on first LED → sequence 2, 3, 4, 2, 3, 5. Two 4-cycle mostra_leds windows. One conta_jogada pulse in state 4.
- Correct play, last round (fim_rodada=1, fim_jogo=1, jogada_igual=1): jogada pulse in state 6 → 7, 8, C with a one-cycle registraR. ganhou=1, pronto=1 held 10 cycles. iniciar → state 1.
- Wrong play: jogada_igual=0 at compara → state E, perdeu=1, timeout=0.
- Timeout (T_INATIVO=8):
  - No jogada → state D exactly 8 cycles after entering 6; timeout=1, perdeu=1.
  - jogada coinciding with cycle 8 → state 7 instead.
